fp_addsub_seq: RTL and testbench

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_addsub_seq_adder.sv | 14 +
 rtl/fp_addsub_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and default sizes for the sequential modular add/sub unit.
package fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam int FP_W_DEFAULT = 64;
  localparam int FP_L_DEFAULT = 8;

endpackage

// File: rtl/fp_addsub_seq_adder.sv
// N-bit ripple adder with carry in/out; the carry chain across limbs is registered by the caller.
module fp_addsub_seq_adder #(
  parameter int N = 64
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule

// File: rtl/fp_addsub_seq.sv
// Limb-serial (a +/- b) mod p: two passes through one shared adder, then a streamed output.
// Define FP_ADDSUB_SEQ_SUB_EN to honour op (subtract); otherwise the unit is add-only.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int W = FP_W_DEFAULT,
  parameter int L = FP_L_DEFAULT,
  localparam int IW = (L > 1) ? $clog2(L) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  output logic [IW-1:0] idx,
  input  logic [W-1:0]  a_limb,
  input  logic [W-1:0]  b_limb,
  input  logic [W-1:0]  p_limb,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  res_limb,
  output logic          out_last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(L - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  state_e          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            c1_q, c1_d;
  logic            c2_q, c2_d;
  logic [W-1:0]    s_buf_q [L];
  logic [W-1:0]    s_buf_d [L];
  logic [W-1:0]    t_buf_q [L];
  logic [W-1:0]    t_buf_d [L];
  logic [W-1:0]    res_q, res_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;

  logic [W-1:0]    add_a_s, add_b_s, sum_s;
  logic            cin_init_s, cin_s, cout_s;
  logic            cnt_last_s, sel_t_s;
  logic [IW-1:0]   rd_ptr_s;

`ifdef FP_ADDSUB_SEQ_SUB_EN
  logic sub_q, sub_d;

  always_comb begin
    sub_d = sub_q;
    if (state_q == ST_IDLE && start) begin
      sub_d = op;
    end else begin
      sub_d = sub_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end

  // Sub: pass 1 forms a + ~b + 1, pass 2 adds p back; add: pass 2 forms s + ~p + 1.
  always_comb begin
    add_a_s    = a_limb;
    add_b_s    = b_limb;
    cin_init_s = 1'b0;
    if (state_q == ST_PASS2) begin
      add_a_s    = s_buf_q[cnt_q];
      add_b_s    = sub_q ? p_limb : ~p_limb;
      cin_init_s = ~sub_q;
    end else begin
      add_a_s    = a_limb;
      add_b_s    = sub_q ? ~b_limb : b_limb;
      cin_init_s = sub_q;
    end
  end

  assign sel_t_s = sub_q ? ~c1_q : (c1_q | c2_q);
`else
  logic unused_op_s;
  assign unused_op_s = op;

  always_comb begin
    add_a_s    = a_limb;
    add_b_s    = b_limb;
    cin_init_s = 1'b0;
    if (state_q == ST_PASS2) begin
      add_a_s    = s_buf_q[cnt_q];
      add_b_s    = ~p_limb;
      cin_init_s = 1'b1;
    end else begin
      add_a_s    = a_limb;
      add_b_s    = b_limb;
      cin_init_s = 1'b0;
    end
  end

  assign sel_t_s = c1_q | c2_q;
`endif

  assign cin_s      = (cnt_q == '0) ? cin_init_s : carry_q;
  assign cnt_last_s = (cnt_q == LAST_IDX);

  fp_addsub_seq_adder #(.N(W)) u_adder (
    .a_i    (add_a_s),
    .b_i    (add_b_s),
    .cin_i  (cin_s),
    .sum_o  (sum_s),
    .cout_o (cout_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    s_buf_d  = s_buf_q;
    t_buf_d  = t_buf_q;
    res_d    = res_q;
    valid_d  = valid_q;
    last_d   = last_q;
    rd_ptr_s = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PASS1;
          cnt_d   = '0;
          carry_d = 1'b0;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_PASS1: begin
        s_buf_d[cnt_q] = sum_s;
        carry_d        = cout_s;
        if (cnt_last_s) begin
          c1_d    = cout_s;
          cnt_d   = '0;
          state_d = ST_PASS2;
        end else begin
          cnt_d   = cnt_q + ONE_IDX;
        end
      end
      ST_PASS2: begin
        t_buf_d[cnt_q] = sum_s;
        carry_d        = cout_s;
        if (cnt_last_s) begin
          c2_d    = cout_s;
          cnt_d   = '0;
          state_d = ST_OUT;
        end else begin
          cnt_d   = cnt_q + ONE_IDX;
        end
      end
      ST_OUT: begin
        // The output register is primed one cycle after entry, then refilled on each acceptance.
        if (!valid_q) begin
          rd_ptr_s = cnt_q;
          valid_d  = 1'b1;
          res_d    = sel_t_s ? t_buf_q[rd_ptr_s] : s_buf_q[rd_ptr_s];
          last_d   = (rd_ptr_s == LAST_IDX);
        end else if (out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            res_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            rd_ptr_s = cnt_q + ONE_IDX;
            cnt_d    = rd_ptr_s;
            res_d    = sel_t_s ? t_buf_q[rd_ptr_s] : s_buf_q[rd_ptr_s];
            last_d   = (rd_ptr_s == LAST_IDX);
          end
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Limb buffers carry no reset; their contents are only read after being written.
  always_ff @(posedge clk) begin
    s_buf_q <= s_buf_d;
    t_buf_q <= t_buf_d;
  end

  assign idx       = (state_q == ST_PASS1 || state_q == ST_PASS2) ? cnt_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = valid_q;
  assign res_limb  = res_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq (W=8, L=2) against a modular-arithmetic reference.
module tb_fp_addsub_seq;

  localparam int W  = 8;
  localparam int L  = 2;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          rst, start, op, out_ready;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_limb, b_limb, p_limb, res_limb;
  logic          busy, out_valid, out_last;
  logic [W*L-1:0] a_v, b_v, p_v;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign a_limb = a_v[idx*W +: W];
  assign b_limb = b_v[idx*W +: W];
  assign p_limb = p_v[idx*W +: W];

  fp_addsub_seq #(.W(W), .L(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .idx       (idx),
    .a_limb    (a_limb),
    .b_limb    (b_limb),
    .p_limb    (p_limb),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_limb  (res_limb),
    .out_last  (out_last)
  );

  function automatic logic [15:0] model(input int a, input int b, input int p, input bit o);
    bit s;
    int r;
    s = o;
`ifndef FP_ADDSUB_SEQ_SUB_EN
    s = 1'b0;
`endif
    if (s) r = (a >= b) ? (a - b) : (a - b + p);
    else   r = (a + b >= p) ? (a + b - p) : (a + b);
    return 16'(r);
  endfunction

  // Runs one operation; returns collected limbs, latency, out_last per limb, hold violations, busy after.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p, input bit o,
                       input int stall_n, input bit rnd_ready, input bit noise,
                       output logic [15:0] res, output int lat, output logic [L-1:0] lasts,
                       output int hold_bad, output logic busy_after);
    int got, guard, stalls;
    bit prev_stall;
    logic [W-1:0]  h_res;
    logic          h_last;
    logic [IW-1:0] h_idx;
    got = 0; guard = 0; stalls = 0; prev_stall = 1'b0;
    h_res = '0; h_last = 1'b0; h_idx = '0;
    res = '0; lasts = '0; hold_bad = 0;
    @(negedge clk);
    a_v = a; b_v = b; p_v = p; op = o; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!out_valid && guard < 40) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        op    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
      guard++;
    end
    start = 1'b0;
    while (got < L && guard < 200) begin
      if (prev_stall && (!out_valid || res_limb !== h_res || out_last !== h_last || idx !== h_idx))
        hold_bad++;
      prev_stall = 1'b0;
      if (out_valid) begin
        if (stalls < stall_n || (rnd_ready && $urandom_range(0, 2) == 0)) begin
          out_ready  = 1'b0;
          prev_stall = 1'b1;
          h_res = res_limb; h_last = out_last; h_idx = idx;
          stalls++;
        end else begin
          out_ready = 1'b1;
          res[got*W +: W] = res_limb;
          lasts[got] = out_last;
          got++;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    out_ready  = 1'b0;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; out_ready = 1'b0;
    a_v = '0; b_v = '0; p_v = 16'h00FB;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, out_valid, out_last} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags: got %b expected 000", {busy, out_valid, out_last});
    end
    tests_run++;
    if (idx !== 1'b0) begin
      tests_failed++; $display("FAIL reset_idx: got %0d expected 0", idx);
    end
    tests_run++;
    if (res_limb !== 8'h00) begin
      tests_failed++; $display("FAIL reset_res: got %h expected 00", res_limb);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [15:0] r; int lat, hb; logic [L-1:0] ls; logic ba;
    do_op(16'h00FA, 16'h0001, 16'h00FB, 1'b0, 0, 1'b0, 1'b0, r, lat, ls, hb, ba);
    tests_run++;
    if (r !== 16'h0000) begin tests_failed++; $display("FAIL add_wrap_res: got %h expected 0000", r); end
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("FAIL add_latency: got %0d expected 5", lat); end
    tests_run++;
    if (ls !== 2'b10) begin tests_failed++; $display("FAIL add_wrap_last: got %b expected 10", ls); end
    do_op(16'h00C8, 16'h0064, 16'h00FB, 1'b0, 0, 1'b0, 1'b0, r, lat, ls, hb, ba);
    tests_run++;
    if (r !== 16'h0031) begin tests_failed++; $display("FAIL add_res: got %h expected 0031", r); end
    tests_run++;
    if (ls !== 2'b10) begin tests_failed++; $display("FAIL add_last: got %b expected 10", ls); end
    tests_run++;
    if (ba !== 1'b0) begin tests_failed++; $display("FAIL add_busy_after: got %b expected 0", ba); end
  endtask

  task automatic test_sub();
    logic [15:0] r; int lat, hb; logic [L-1:0] ls; logic ba;
`ifdef FP_ADDSUB_SEQ_SUB_EN
    do_op(16'h0005, 16'h0007, 16'h00FB, 1'b1, 0, 1'b0, 1'b0, r, lat, ls, hb, ba);
    tests_run++;
    if (r !== 16'h00F9) begin tests_failed++; $display("FAIL sub_borrow: got %h expected 00f9", r); end
    do_op(16'h0007, 16'h0005, 16'h00FB, 1'b1, 0, 1'b0, 1'b0, r, lat, ls, hb, ba);
    tests_run++;
    if (r !== 16'h0002) begin tests_failed++; $display("FAIL sub_plain: got %h expected 0002", r); end
`else
    do_op(16'h0005, 16'h0007, 16'h00FB, 1'b1, 0, 1'b0, 1'b0, r, lat, ls, hb, ba);
    tests_run++;
    if (r !== 16'h000C) begin tests_failed++; $display("FAIL addonly_op1: got %h expected 000c", r); end
`endif
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("FAIL sub_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_stall();
    logic [15:0] r; int lat, hb; logic [L-1:0] ls; logic ba;
    do_op(16'h0003, 16'h0004, 16'h00FB, 1'b0, 3, 1'b0, 1'b0, r, lat, ls, hb, ba);
    tests_run++;
    if (r !== 16'h0007) begin tests_failed++; $display("FAIL stall_res: got %h expected 0007", r); end
    tests_run++;
    if (hb !== 0) begin tests_failed++; $display("FAIL stall_hold: got %0d violations expected 0", hb); end
    tests_run++;
    if (ba !== 1'b0) begin tests_failed++; $display("FAIL stall_busy_after: got %b expected 0", ba); end
    tests_run++;
    if (idx !== 1'b0) begin tests_failed++; $display("FAIL idle_idx: got %0d expected 0", idx); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; int lat, hb; logic [L-1:0] ls; logic ba;
    @(negedge clk);
    a_v = 16'h0055; b_v = 16'h0066; p_v = 16'h00FB; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, out_valid, out_last} !== 3'b000) begin
      tests_failed++; $display("FAIL mid_rst_flags: got %b expected 000", {busy, out_valid, out_last});
    end
    tests_run++;
    if (idx !== 1'b0 || res_limb !== 8'h00) begin
      tests_failed++; $display("FAIL mid_rst_out: got idx %0d res %h expected 0 00", idx, res_limb);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0010, 16'h0020, 16'h00FB, 1'b0, 0, 1'b0, 1'b0, r, lat, ls, hb, ba);
    tests_run++;
    if (r !== 16'h0030) begin tests_failed++; $display("FAIL post_rst_res: got %h expected 0030", r); end
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("FAIL post_rst_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_random();
    logic [15:0] r, exp, a, b, p; int lat, hb; logic [L-1:0] ls; logic ba; bit o;
    for (int i = 0; i < 30; i++) begin
      p = 16'($urandom_range(3, 16'hFFFF));
      a = 16'($urandom_range(0, int'(p) - 1));
      b = 16'($urandom_range(0, int'(p) - 1));
      o = 1'($urandom_range(0, 1));
      exp = model(int'(a), int'(b), int'(p), o);
      do_op(a, b, p, o, 0, 1'b1, 1'b1, r, lat, ls, hb, ba);
      tests_run++;
      if (r !== exp) begin
        tests_failed++;
        $display("FAIL rand_res[%0d]: a=%h b=%h p=%h op=%b got %h expected %h", i, a, b, p, o, r, exp);
      end
      tests_run++;
      if (lat !== 5 || ls !== 2'b10 || hb !== 0 || ba !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_proto[%0d]: got lat %0d last %b hold %0d busy %b expected 5 10 0 0",
                 i, lat, ls, hb, ba);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
